unpad: RTL and testbench

- Strips a fixed-width border from a raster-order 8-bit pixel stream. Input frames are (WIDTH+2·PAD) × (HEIGHT+2·PAD); output frames are WIDTH × HEIGHT.
- It is the inverse of the zero-padding stage. It sits after window/convolution stages that operate on padded frames, and restores native frame geometry before frame consumers.
- Upstream and downstream interfaces are valid/ready streams.
- Output is registered through a single pipeline stage.

---
 rtl/unpad.sv | 90 +++++++++
 tb/tb_unpad.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpad.sv
// unpad: removes a PAD-pixel border from a raster-order 8-bit pixel stream.
// Input frames are (WIDTH+2*PAD) x (HEIGHT+2*PAD); only interior pixels
// are forwarded, through a single registered output stage.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// its valid and ready are both high. valid (and the data it qualifies)
// must not be withdrawn or altered while the receiver holds ready low.
// ready_out may depend on ready_in combinationally; valid_out never
// depends on ready_in.
module unpad #(
    parameter int WIDTH  = 6,
    parameter int HEIGHT = 6,
    parameter int PAD    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       last_out,
    input  logic       ready_in
);

    localparam int PW = WIDTH + 2 * PAD;
    localparam int PH = HEIGHT + 2 * PAD;
    localparam int XW = $clog2(PW) + 1;
    localparam int YW = $clog2(PH) + 1;

    localparam logic [XW-1:0] X_LO  = XW'(PAD);
    localparam logic [XW-1:0] X_HI  = XW'(PAD + WIDTH - 1);
    localparam logic [XW-1:0] X_END = XW'(PW - 1);
    localparam logic [YW-1:0] Y_LO  = YW'(PAD);
    localparam logic [YW-1:0] Y_HI  = YW'(PAD + HEIGHT - 1);
    localparam logic [YW-1:0] Y_END = YW'(PH - 1);

    // Position of the beat currently offered on data_in.
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic interior;
    logic accept;
    logic last_pix;

    // Classify the offered beat; border beats never wait on the output stage.
    always_comb begin
        interior  = (x >= X_LO) && (x <= X_HI) && (y >= Y_LO) && (y <= Y_HI);
        ready_out = !interior || !valid_out || ready_in;
        accept    = valid_in && ready_out;
        last_pix  = (x == X_HI) && (y == Y_HI);
    end

    // Raster position counters; frame alignment comes purely from beat count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (x == X_END) begin
                x <= '0;
                if (y == Y_END) begin
                    y <= '0;
                end else begin
                    y <= y + YW'(1);
                end
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Output stage: load on interior accept (covers pop-and-load in one
    // cycle), clear qualifiers on a plain pop, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (accept && interior) begin
            data_out  <= data_in;
            valid_out <= 1'b1;
            last_out  <= last_pix;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_unpad.sv
// Directed bench for unpad: two geometries, scoreboard of expected interior
// pixels, per-cycle handshake model, and table-driven spot checks.
module tb_unpad;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_in;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic       a_ro, a_vo, a_lo;
    logic [7:0] a_do;
    logic       b_ro, b_vo, b_lo;
    logic [7:0] b_do;

    unpad #(.WIDTH(6), .HEIGHT(6), .PAD(1)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(a_ro), .data_out(a_do), .valid_out(a_vo), .last_out(a_lo),
        .ready_in(ready_in)
    );

    unpad #(.WIDTH(4), .HEIGHT(3), .PAD(2)) dut_b (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(b_ro), .data_out(b_do), .valid_out(b_vo), .last_out(b_lo),
        .ready_in(ready_in)
    );

    // Selected DUT as seen by the monitor and driver.
    logic       sel = 1'b0;
    logic       ro, vo, lo;
    logic [7:0] dout;
    always_comb begin
        ro   = sel ? b_ro : a_ro;
        vo   = sel ? b_vo : a_vo;
        lo   = sel ? b_lo : a_lo;
        dout = sel ? b_do : a_do;
    end

    // Geometry of the selected DUT.
    int pw = 8, ph = 8, gw = 6, gh = 6, pd = 1;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] exp_q[$];   // {last, data}
    logic [7:0] got_q[$];
    int         got_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected interior pixels for the first nb beats of a frame starting at base.
    task automatic push_frame(input int base, input int nb);
        for (int yy = pd; yy < pd + gh; yy++) begin
            for (int xx = pd; xx < pd + gw; xx++) begin
                if (yy * pw + xx < nb)
                    exp_q.push_back({1'(yy == pd + gh - 1 && xx == pd + gw - 1),
                                     8'(base + yy * pw + xx)});
            end
        end
    endtask

    // ---------------- monitor / handshake model ----------------
    int   mx = 0, my = 0;
    bit   pend = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_d;
    logic prev_l;

    always @(negedge clk) begin : monitor
        bit m_int, m_rdy;
        logic [8:0] e;
        if (reset) begin
            mx = 0; my = 0; pend = 0; prev_stall = 0;
        end else begin
            m_int = (mx >= pd) && (mx < pd + gw) && (my >= pd) && (my < pd + gh);
            m_rdy = !m_int || !pend || ready_in;
            chk("ready_out", 32'(ro), 32'(m_rdy));
            chk("valid_out", 32'(vo), 32'(pend));
            if (prev_stall) begin
                chk("stall_data", 32'(dout), 32'(prev_d));
                chk("stall_last", 32'(lo), 32'(prev_l));
            end
            if (vo && ready_in) begin
                got_q.push_back(dout);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(dout), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(dout), 32'(e[7:0]));
                    chk("last_out", 32'(lo), 32'(e[8]));
                end
            end
            prev_stall = vo && !ready_in;
            prev_d     = dout;
            prev_l     = lo;
            // Advance the model for the coming clock edge.
            if (valid_in && m_rdy && m_int) pend = 1;
            else if (pend && ready_in) pend = 0;
            if (valid_in && m_rdy) begin
                if (mx == pw - 1) begin
                    mx = 0;
                    my = (my == ph - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beats(input int base, input int n, input int gap, input bit rnd);
        int i = 0;
        int budget = 0;
        bit acc;
        while (i < n && budget < 3000) begin
            data_in  = 8'(base + i);
            valid_in = 1'b1;
            ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = ro;
            @(posedge clk);
            #1;
            budget++;
            if (acc) begin
                i++;
                valid_in = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(posedge clk);
                    #1;
                end
            end
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        chk("beats_accepted", 32'(i), 32'(n));
    endtask

    task automatic drain();
        int k = 0;
        ready_in = 1'b1;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic scen_begin(input bit use_b);
        sel = use_b;
        if (use_b) begin pw = 8; ph = 7; gw = 4; gh = 3; pd = 2; end
        else       begin pw = 8; ph = 8; gw = 6; gh = 6; pd = 1; end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         tab;
        int         idx;
        logic [7:0] data;
        logic       last;
    } vec_t;

    vec_t vecs[18];

    task automatic check_table(input int tab, input int n_out);
        chk("output_count", 32'(got_q.size()), 32'(n_out));
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].tab == tab) begin
                if (vecs[i].idx < got_q.size())
                    chk($sformatf("tab%0d_out%0d", tab, vecs[i].idx),
                        32'(got_q[vecs[i].idx]), 32'(vecs[i].data));
                else
                    chk($sformatf("tab%0d_out%0d_missing", tab, vecs[i].idx),
                        32'(got_q.size()), 32'(vecs[i].idx + 1));
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{1, 0, 8'd9, 1'b0};
        vecs[1]  = '{1, 5, 8'd14, 1'b0};
        vecs[2]  = '{1, 6, 8'd17, 1'b0};
        vecs[3]  = '{1, 11, 8'd22, 1'b0};
        vecs[4]  = '{1, 34, 8'd53, 1'b0};
        vecs[5]  = '{1, 35, 8'd54, 1'b1};
        vecs[6]  = '{3, 35, 8'd54, 1'b1};
        vecs[7]  = '{3, 36, 8'd109, 1'b0};
        vecs[8]  = '{3, 41, 8'd114, 1'b0};
        vecs[9]  = '{3, 71, 8'd154, 1'b1};
        vecs[10] = '{5, 0, 8'd18, 1'b0};
        vecs[11] = '{5, 3, 8'd21, 1'b0};
        vecs[12] = '{5, 4, 8'd26, 1'b0};
        vecs[13] = '{5, 7, 8'd29, 1'b0};
        vecs[14] = '{5, 8, 8'd34, 1'b0};
        vecs[15] = '{5, 11, 8'd37, 1'b1};
        vecs[16] = '{5, 10, 8'd36, 1'b0};
        vecs[17] = '{1, 12, 8'd25, 1'b0};

        reset    = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        data_in  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state of both instances.
        chk("rst_a_valid", 32'(a_vo), 32'd0);
        chk("rst_a_last", 32'(a_lo), 32'd0);
        chk("rst_a_data", 32'(a_do), 32'd0);
        chk("rst_a_ready", 32'(a_ro), 32'd1);
        chk("rst_b_valid", 32'(b_vo), 32'd0);
        chk("rst_b_last", 32'(b_lo), 32'd0);
        chk("rst_b_data", 32'(b_do), 32'd0);
        reset = 1'b0;

        // 1: continuous stream, downstream always ready.
        scen_begin(1'b0);
        push_frame(0, 64);
        drive_beats(0, 64, 0, 1'b0);
        drain();
        check_table(1, 36);
        if (got_cyc.size() >= 7) begin
            chk("row1_throughput", 32'(got_cyc[5] - got_cyc[0]), 32'd5);
            chk("row_gap", 32'(got_cyc[6] - got_cyc[5]), 32'd3);
        end

        // 2: same stream, downstream ready toggling.
        scen_begin(1'b0);
        push_frame(0, 64);
        drive_beats(0, 64, 0, 1'b1);
        drain();
        check_table(1, 36);

        // 3: two back-to-back frames.
        scen_begin(1'b0);
        push_frame(0, 64);
        push_frame(100, 64);
        drive_beats(0, 64, 0, 1'b0);
        drive_beats(100, 64, 0, 1'b0);
        drain();
        check_table(3, 72);
        if (got_cyc.size() >= 37)
            chk("frame_gap", 32'(got_cyc[36] - got_cyc[35]), 32'd19);

        // 4: reset after 30 accepted beats, then a full frame.
        scen_begin(1'b0);
        push_frame(0, 30);
        drive_beats(0, 30, 0, 1'b0);
        chk("pre_rst_pending", 32'(exp_q.size()), 32'd1);
        chk("pre_rst_valid", 32'(a_vo), 32'd1);
        chk("pre_rst_data", 32'(a_do), 32'd29);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(a_vo), 32'd0);
        chk("rst_mid_last", 32'(a_lo), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        push_frame(0, 64);
        drive_beats(0, 64, 0, 1'b0);
        drain();
        check_table(1, 36);

        // 5: 4x3 interior with a 2-pixel border.
        scen_begin(1'b1);
        push_frame(0, 56);
        drive_beats(0, 56, 0, 1'b0);
        drain();
        check_table(5, 12);

        // 6: gapped input, one beat every third cycle.
        scen_begin(1'b0);
        push_frame(0, 64);
        drive_beats(0, 64, 2, 1'b0);
        drain();
        check_table(1, 36);
        if (got_cyc.size() >= 2)
            chk("gapped_spacing", 32'(got_cyc[1] - got_cyc[0]), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
